// File: rtl/cc_display_scanner.sv
// Two-digit hex display scan controller: prescaled digit multiplexing with a
// double-buffered value that only swaps in on a scan-frame boundary.
module cc_display_scanner #(
  parameter int DATAWIDTH_VALUE             = 8,
  parameter int DATAWIDTH_DECODER_SELECTION = 2,
  parameter int DATAWIDTH_NIBBLE            = 4,
  parameter int PRESCALER_MAX               = 50000,
  parameter int PRESCALER_WIDTH             = 16
) (
  input  logic                                   CC_DISPLAY_SCANNER_CLOCK_50,
  input  logic                                   CC_DISPLAY_SCANNER_RESET_InLow,
  input  logic [DATAWIDTH_VALUE-1:0]             CC_DISPLAY_SCANNER_value_InBUS,
  input  logic                                   CC_DISPLAY_SCANNER_load_In,
  input  logic                                   CC_DISPLAY_SCANNER_enable_In,
  input  logic                                   CC_DISPLAY_SCANNER_blankzero_In,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_DISPLAY_SCANNER_selection_OutBUS,
  output logic [DATAWIDTH_NIBBLE-1:0]            CC_DISPLAY_SCANNER_nibble_OutBUS,
  output logic                                   CC_DISPLAY_SCANNER_loadack_Out,
  output logic                                   CC_DISPLAY_SCANNER_pending_Out
);
  typedef enum logic {DIGIT0 = 1'b0, DIGIT1 = 1'b1} state_t;

  localparam logic [PRESCALER_WIDTH-1:0] CNT_LAST = PRESCALER_WIDTH'(PRESCALER_MAX - 1);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] SEL_D0  = '0;
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] SEL_D1  = DATAWIDTH_DECODER_SELECTION'(1);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] SEL_OFF = '1;

  logic [PRESCALER_WIDTH-1:0]             count_q, count_d;
  state_t                                 state_q, state_d;
  logic                                   run_q, run_d;
  logic [DATAWIDTH_VALUE-1:0]             shown_q, shown_d;
  logic [DATAWIDTH_VALUE-1:0]             pend_q, pend_d;
  logic                                   flag_q, flag_d;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] sel_q, sel_d;
  logic [DATAWIDTH_NIBBLE-1:0]            nib_q, nib_d;
  logic                                   ack_q, ack_d;
  logic                                   tick;
  logic [DATAWIDTH_NIBBLE-1:0]            hi_nib;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    run_d   = run_q;
    shown_d = shown_q;
    pend_d  = pend_q;
    flag_d  = flag_q;
    ack_d   = 1'b0;
    tick    = 1'b0;

    if (!CC_DISPLAY_SCANNER_enable_In) begin
      // Blanked: nothing visible can tear, so a pending value swaps in at once.
      count_d = '0;
      state_d = DIGIT0;
      run_d   = 1'b0;
      if (flag_q) begin
        shown_d = pend_q;
        flag_d  = 1'b0;
        ack_d   = 1'b1;
      end
    end else if (!run_q) begin
      // First enabled edge opens a full-length DIGIT0 dwell.
      run_d   = 1'b1;
      count_d = '0;
      state_d = DIGIT0;
    end else begin
      tick    = (count_q == CNT_LAST);
      count_d = tick ? '0 : count_q + PRESCALER_WIDTH'(1);
      if (tick) begin
        state_d = (state_q == DIGIT0) ? DIGIT1 : DIGIT0;
        if (state_q == DIGIT1 && flag_q) begin
          shown_d = pend_q;
          flag_d  = 1'b0;
          ack_d   = 1'b1;
        end
      end
    end

    // A same-edge load lands in pending after any transfer of the older value.
    if (CC_DISPLAY_SCANNER_load_In) begin
      pend_d = CC_DISPLAY_SCANNER_value_InBUS;
      flag_d = 1'b1;
    end

    hi_nib = shown_d[2*DATAWIDTH_NIBBLE-1:DATAWIDTH_NIBBLE];
    if (!CC_DISPLAY_SCANNER_enable_In) begin
      sel_d = SEL_OFF;
      nib_d = '0;
    end else if (state_d == DIGIT0) begin
      sel_d = SEL_D0;
      nib_d = shown_d[DATAWIDTH_NIBBLE-1:0];
    end else if (CC_DISPLAY_SCANNER_blankzero_In && hi_nib == '0) begin
      sel_d = SEL_OFF;
      nib_d = '0;
    end else begin
      sel_d = SEL_D1;
      nib_d = hi_nib;
    end
  end

  always_ff @(posedge CC_DISPLAY_SCANNER_CLOCK_50 or negedge CC_DISPLAY_SCANNER_RESET_InLow) begin
    if (!CC_DISPLAY_SCANNER_RESET_InLow) begin
      count_q <= '0;
      state_q <= DIGIT0;
      run_q   <= 1'b0;
      shown_q <= '0;
      pend_q  <= '0;
      flag_q  <= 1'b0;
      sel_q   <= SEL_OFF;
      nib_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      run_q   <= run_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      sel_q   <= sel_d;
      nib_q   <= nib_d;
      ack_q   <= ack_d;
    end
  end

  assign CC_DISPLAY_SCANNER_selection_OutBUS = sel_q;
  assign CC_DISPLAY_SCANNER_nibble_OutBUS    = nib_q;
  assign CC_DISPLAY_SCANNER_loadack_Out      = ack_q;
  assign CC_DISPLAY_SCANNER_pending_Out      = flag_q;

endmodule

// File: tb/tb_cc_display_scanner.sv
// Directed bench for cc_display_scanner with a frame-phase reference model
// feeding an expected-output queue.
module tb_cc_display_scanner;
  logic       clk, rst_n, ld, en, bz;
  logic [7:0] val;
  logic [1:0] sel_o;
  logic [3:0] nib_o;
  logic       ack_o, pnd_o;

  int nvec = 0;
  int nmis = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] nib;
    logic       ack;
    logic       pnd;
  } obs_t;

  obs_t sb[$];

  // Reference model: frame position 0..7 (0-3 digit 0, 4-7 digit 1).
  bit         m_run;
  int         m_ph;
  logic [7:0] m_shown, m_pv;
  bit         m_fl;

  cc_display_scanner #(.PRESCALER_MAX(4), .PRESCALER_WIDTH(16)) dut (
    .CC_DISPLAY_SCANNER_CLOCK_50        (clk),
    .CC_DISPLAY_SCANNER_RESET_InLow     (rst_n),
    .CC_DISPLAY_SCANNER_value_InBUS     (val),
    .CC_DISPLAY_SCANNER_load_In         (ld),
    .CC_DISPLAY_SCANNER_enable_In       (en),
    .CC_DISPLAY_SCANNER_blankzero_In    (bz),
    .CC_DISPLAY_SCANNER_selection_OutBUS(sel_o),
    .CC_DISPLAY_SCANNER_nibble_OutBUS   (nib_o),
    .CC_DISPLAY_SCANNER_loadack_Out     (ack_o),
    .CC_DISPLAY_SCANNER_pending_Out     (pnd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_run = 0; m_ph = 0; m_shown = 8'h00; m_pv = 8'h00; m_fl = 0;
    sb.delete();
  endtask

  task automatic check(input string tag, input obs_t exp_v);
    obs_t o;
    o = {sel_o, nib_o, ack_o, pnd_o};
    nvec++;
    assert (o === exp_v) else begin
      nmis++;
      $error("FAIL %s t=%0t sel/nib/ack/pend got %b/%h/%b/%b want %b/%h/%b/%b", tag, $time,
             o.sel, o.nib, o.ack, o.pnd, exp_v.sel, exp_v.nib, exp_v.ack, exp_v.pnd);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic cyc(input logic l, input logic [7:0] v);
    obs_t e;
    logic a;
    ld = l; val = v; a = 1'b0;
    if (!en) begin
      m_run = 0; m_ph = 0;
      if (m_fl) begin m_shown = m_pv; m_fl = 0; a = 1'b1; end
    end else if (!m_run) begin
      m_run = 1; m_ph = 0;
    end else begin
      m_ph = (m_ph + 1) % 8;
      if (m_ph == 0 && m_fl) begin m_shown = m_pv; m_fl = 0; a = 1'b1; end
    end
    if (l) begin m_pv = v; m_fl = 1; end
    e.ack = a;
    e.pnd = m_fl;
    if (!en)                              begin e.sel = 2'b11; e.nib = 4'h0; end
    else if (m_ph < 4)                    begin e.sel = 2'b00; e.nib = m_shown[3:0]; end
    else if (bz && m_shown[7:4] == 4'h0)  begin e.sel = 2'b11; e.nib = 4'h0; end
    else                                  begin e.sel = 2'b01; e.nib = m_shown[7:4]; end
    sb.push_back(e);
    @(posedge clk);
    #1;
    ld = 1'b0;
    check("scan", sb.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic to_ph(input int t);
    for (int i = 0; i < 16 && m_ph != t; i++) cyc(1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; en = 1'b0; bz = 1'b0; val = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", {2'b11, 4'h0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan of the reset value.
    en = 1'b1;
    run(10);

    // Single load in digit 0, then two loads in one frame (last wins).
    to_ph(1);
    cyc(1'b1, 8'hA5);
    run(18);
    to_ph(1);
    cyc(1'b1, 8'h11);
    run(2);
    cyc(1'b1, 8'h22);
    run(16);

    // Load on the frame-end edge, first with nothing pending, then with 0x33 pending.
    to_ph(7);
    cyc(1'b1, 8'h07);
    run(16);
    to_ph(2);
    cyc(1'b1, 8'h33);
    to_ph(7);
    cyc(1'b1, 8'h07);
    run(16);

    // Leading-zero blanking of digit 1 on 0x07.
    bz = 1'b1;
    run(8);
    bz = 1'b0;
    run(8);

    // Disable mid-digit-1 with 0x3C pending, then re-enable.
    to_ph(4);
    cyc(1'b1, 8'h3C);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(10);

    // Asynchronous reset mid-frame with a value pending.
    cyc(1'b1, 8'h99);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {2'b11, 4'h0, 1'b0, 1'b0});
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cc_display_scanner.md
# cc_display_scanner

Time-multiplexing scan controller for the two-digit hex display of the Collatz result. Holds the value being shown, steps a digit index at a prescaled rate, and drives the 2-bit digit-selection bus consumed by the display decoder (00 = digit 0 enable, 01 = digit 1 enable, 11 = all digits off) plus the 4-bit nibble consumed by the seven-segment encoder. New values are double-buffered and take effect only on a scan-frame boundary, so a displayed frame never mixes digits from two values.

## Interface
- DATAWIDTH_VALUE, 8, width of displayed value (two nibbles)
- DATAWIDTH_DECODER_SELECTION, 2, width of selection bus to the decoder
- DATAWIDTH_NIBBLE, 4, width of nibble to the segment encoder
- PRESCALER_MAX, 50000, clock cycles per digit dwell (1 ms at 50 MHz); must be ≥ 2
- PRESCALER_WIDTH, 16, prescaler counter width; must hold PRESCALER_MAX-1
- CC_DISPLAY_SCANNER_CLOCK_50  input  1  system clock; all state updates on rising edge
- CC_DISPLAY_SCANNER_RESET_InLow  input  1  reset, asynchronous, active-low
- CC_DISPLAY_SCANNER_value_InBUS  input  DATAWIDTH_VALUE  value to display, sampled when load_In=1
- CC_DISPLAY_SCANNER_load_In  input  1  load strobe, one sample per high cycle
- CC_DISPLAY_SCANNER_enable_In  input  1  1 = scan running, 0 = display blanked
- CC_DISPLAY_SCANNER_blankzero_In  input  1  1 = blank digit 1 when its nibble is 0
- CC_DISPLAY_SCANNER_selection_OutBUS  output  DATAWIDTH_DECODER_SELECTION  digit select to decoder
- CC_DISPLAY_SCANNER_nibble_OutBUS  output  DATAWIDTH_NIBBLE  nibble for the active digit
- CC_DISPLAY_SCANNER_loadack_Out  output  1  one-cycle pulse: pending value became shown value
- CC_DISPLAY_SCANNER_pending_Out  output  1  1 = a loaded value awaits the frame boundary

## Operation
- Registers: prescaler count, state {DIGIT0, DIGIT1}, shown[7:0], pending[7:0], pending flag; all outputs registered.
- Reset (async, while RESET_InLow=0): count=0, state=DIGIT0, shown=0, pending=0, flag=0; selection=2'b11, nibble=4'h0, loadack=0, pending_Out=0. Reset asserted mid-frame aborts the frame and drops any pending value.
- Prescaler (enable=1): tick is high when count==PRESCALER_MAX-1; count then wraps to 0, else increments.
- State on tick: DIGIT0→DIGIT1, DIGIT1→DIGIT0. A tick in DIGIT1 is the frame end.
- Outputs follow the new state: DIGIT0 → selection 00, nibble shown[3:0]. DIGIT1 → selection 01, nibble shown[7:4]. Exception: if blankzero_In=1 and shown[7:4]==0, DIGIT1 drives selection 11 and nibble 0. Digit 0 is never blanked.
- Load: load_In=1 copies value_InBUS into pending and sets the flag. A load while already pending overwrites it (last wins).
- Transfer (enable=1): at frame end, if the flag was set before this edge, shown←pending, flag clears, loadack=1 for exactly one cycle. A load on the same edge as the frame end keeps the flag set with the new value and transfers it at the next frame end. An older pending value is transferred on that edge, and the new value replaces it in pending.
- Disable (enable=0): next edge count=0, state=DIGIT0, selection=11, nibble=0. Any pending value transfers on the first edge with the flag set, with a loadack pulse, because no frame tearing is possible while blanked.
- Re-enable: first edge with enable=1 shows DIGIT0 and starts counting from 0.

## Timing
- Digit dwell is exactly PRESCALER_MAX cycles, and a frame is 2×PRESCALER_MAX cycles.
- The selection and nibble outputs change on the same edge as the tick-driven state change.
- Load-to-display latency is 1 cycle minimum (disabled) and at most 2×PRESCALER_MAX+1 cycles (enabled).
- The loadack pulse is aligned with the first cycle the new shown value is visible.
- The pending_Out output mirrors the flag and rises the cycle after the load edge.
- Inputs are synchronous to the clock. blankzero_In and enable_In take effect on the next edge.

## Test plan
Use PRESCALER_MAX=4 for all scenarios.
- Reset then enable=1, no load: selection 11 during reset, then 00,00,00,00,01,01,01,01 repeating. Nibble is 0 throughout.
- Load 0xA5 in DIGIT0 (enabled): pending_Out=1 next cycle. At frame end, loadack pulses and pending clears. The next frame shows nibble 5 with select 00 (4 cycles), then A with select 01 (4 cycles).
- Load 0x11 then 0x22 within one frame: only 0x22 is displayed, with a single loadack pulse.
- Load 0x07 coinciding with a frame-end tick, with no prior pending: no ack that edge. The value is shown after the following frame end with one loadack. Repeat with 0x33 already pending: 0x33 is shown immediately and 0x07 stays pending.
- Shown 0x07 with blankzero=1: DIGIT1 slots drive 11/0 and DIGIT0 slots drive 00/7. With blankzero=0, DIGIT1 drives 01/0.
- enable=0 mid-DIGIT1 with 0x3C pending: next edge gives selection 11, and 0x3C transfers with loadack. Re-enable gives 00/C for 4 cycles, then 01/3. Async reset mid-frame forces selection 11 and clears pending immediately.
